// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, jump redirect and branch-resolution hold for the 5-stage MIPS core.
// Optional hazard statistics counters are built only when HAZARD_STATS_EN is defined.

// state   | meaning
// NORM    | normal decode of the ID instruction (load-use, jump, branch, pass)
// BR_WAIT | branch is in EX, ID holds a NOP, waiting on EX_BranchTaken
module hazard_unit
`ifdef HAZARD_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic       CLK,
   input  logic       Reset_L,
   input  logic       Jump,
   input  logic       Branch,
   input  logic       EX_BranchTaken,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_Rw,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       UseShamt,
   input  logic       UseImmed,
   output logic       PCWrite,
   output logic       IFWrite,
   output logic       IFFlush,
   output logic       Bubble,
   output logic [1:0] AddrSel
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
`endif
);

   typedef enum logic {
      NORM    = 1'b0,
      BR_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] SEL_PC4  = 2'b00;
   localparam logic [1:0] SEL_JUMP = 2'b01;
   localparam logic [1:0] SEL_BR   = 2'b10;

   state_t state;
   state_t state_next;
   logic   rs_match;
   logic   rt_match;
   logic   load_use;

   // Register 0 is hardwired, so a load targeting it never blocks ID.
   assign rs_match = !UseShamt && (ID_Rs == EX_Rw);
   assign rt_match = !UseImmed && (ID_Rt == EX_Rw);
   assign load_use = EX_MemRead && (EX_Rw != 5'd0) && !Jump && (rs_match || rt_match);

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state <= NORM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      PCWrite    = 1'b1;
      IFWrite    = 1'b1;
      IFFlush    = 1'b0;
      Bubble     = 1'b0;
      AddrSel    = SEL_PC4;
      if (!Reset_L) begin
         // Reset holds the front end frozen and flushed until released.
         state_next = NORM;
         PCWrite    = 1'b0;
         IFWrite    = 1'b0;
         IFFlush    = 1'b1;
         Bubble     = 1'b1;
      end else begin
         case (state)
            NORM: begin
               if (load_use) begin
                  PCWrite = 1'b0;
                  IFWrite = 1'b0;
                  Bubble  = 1'b1;
               end else if (Jump) begin
                  IFFlush = 1'b1;
                  AddrSel = SEL_JUMP;
               end else if (Branch) begin
                  PCWrite    = 1'b0;
                  IFFlush    = 1'b1;
                  state_next = BR_WAIT;
               end
            end
            BR_WAIT: begin
               state_next = NORM;
               if (EX_BranchTaken) begin
                  IFFlush = 1'b1;
                  AddrSel = SEL_BR;
               end
            end
            default: begin
               state_next = NORM;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic stall_hit;
   logic flush_hit;

   assign stall_hit = (state == NORM) && load_use;
   assign flush_hit = IFFlush;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (stall_hit && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
         end
         if (flush_hit && (FlushCount != '1)) begin
            FlushCount <= FlushCount + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed test-plan cases followed by randomized traffic against a rule model.
// Define HAZARD_STATS_EN to also check the statistics counters (built with CNT_W=4).
module tb_hazard_unit;

   logic       CLK;
   logic       Reset_L;
   logic       Jump;
   logic       Branch;
   logic       EX_BranchTaken;
   logic       EX_MemRead;
   logic [4:0] EX_Rw;
   logic [4:0] ID_Rs;
   logic [4:0] ID_Rt;
   logic       UseShamt;
   logic       UseImmed;
   logic       PCWrite;
   logic       IFWrite;
   logic       IFFlush;
   logic       Bubble;
   logic [1:0] AddrSel;

   int checks = 0;
   int errors = 0;

   // Reference model state: is a branch outstanding in EX, and the expected counter values.
   bit pend = 0;
   int exp_stall = 0;
   int exp_flush = 0;

`ifdef HAZARD_STATS_EN
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   logic [CW-1:0] StallCount;
   logic [CW-1:0] FlushCount;

   hazard_unit #(.CNT_W(CW)) dut (
      .CLK(CLK), .Reset_L(Reset_L), .Jump(Jump), .Branch(Branch),
      .EX_BranchTaken(EX_BranchTaken), .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .UseShamt(UseShamt), .UseImmed(UseImmed),
      .PCWrite(PCWrite), .IFWrite(IFWrite), .IFFlush(IFFlush), .Bubble(Bubble),
      .AddrSel(AddrSel), .StallCount(StallCount), .FlushCount(FlushCount)
   );
`else
   hazard_unit dut (
      .CLK(CLK), .Reset_L(Reset_L), .Jump(Jump), .Branch(Branch),
      .EX_BranchTaken(EX_BranchTaken), .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .UseShamt(UseShamt), .UseImmed(UseImmed),
      .PCWrite(PCWrite), .IFWrite(IFWrite), .IFFlush(IFFlush), .Bubble(Bubble),
      .AddrSel(AddrSel)
   );
`endif

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected {PCWrite,IFWrite,IFFlush,Bubble,AddrSel[1:0]} straight from the operating rules.
   function automatic logic [5:0] expect_ctl(input bit rst_n, input bit br_pend, input bit lu,
                                             input bit j, input bit b, input bit tk);
      if (!rst_n)  return 6'b00_11_00;
      if (br_pend) return tk ? 6'b11_10_10 : 6'b11_00_00;
      if (lu)      return 6'b00_01_00;
      if (j)       return 6'b11_10_01;
      if (b)       return 6'b01_10_00;
      return 6'b11_00_00;
   endfunction

   task automatic step(input string tag, input bit rst_n, input bit j, input bit b, input bit tk,
                       input bit mr, input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt,
                       input bit sh, input bit im);
      bit         lu;
      logic [5:0] exp;
      Reset_L = rst_n; Jump = j; Branch = b; EX_BranchTaken = tk; EX_MemRead = mr;
      EX_Rw = rw; ID_Rs = rs; ID_Rt = rt; UseShamt = sh; UseImmed = im;
      #1;
      lu  = mr && (rw != 0) && !j && ((!sh && rs == rw) || (!im && rt == rw));
      exp = expect_ctl(rst_n, pend, lu, j, b, tk);
      chk(tag, {26'd0, PCWrite, IFWrite, IFFlush, Bubble, AddrSel}, {26'd0, exp});
      @(posedge CLK);
      if (!rst_n) begin
         pend = 0; exp_stall = 0; exp_flush = 0;
      end else begin
         if (!pend && lu && exp_stall < 65535) exp_stall++;
         if (exp[3] && exp_flush < 65535) exp_flush++;
         pend = !pend && !lu && !j && b;
      end
      #1;
`ifdef HAZARD_STATS_EN
      chk({tag, "_stall"}, {28'd0, StallCount}, (exp_stall > CMAX) ? CMAX : exp_stall);
      chk({tag, "_flush"}, {28'd0, FlushCount}, (exp_flush > CMAX) ? CMAX : exp_flush);
`endif
   endtask

   initial begin
      Reset_L = 0; Jump = 0; Branch = 0; EX_BranchTaken = 0; EX_MemRead = 0;
      EX_Rw = 0; ID_Rs = 0; ID_Rt = 0; UseShamt = 0; UseImmed = 0;
      #2;
      chk("reset_ctl", {26'd0, PCWrite, IFWrite, IFFlush, Bubble, AddrSel}, 32'b00_11_00);
      step("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      //               rst j  b  tk mr rw     rs     rt     sh im
      step("lu_rs",     1, 0, 0, 0, 1, 5'd5,  5'd5,  5'd1,  0, 0);
      step("lu_clear",  1, 0, 0, 0, 0, 5'd5,  5'd5,  5'd1,  0, 0);
      step("lu_rt",     1, 0, 0, 0, 1, 5'd7,  5'd2,  5'd7,  0, 0);
      step("sup_r0",    1, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  0, 0);
      step("sup_immed", 1, 0, 0, 0, 1, 5'd9,  5'd3,  5'd9,  0, 1);
      step("sup_shamt", 1, 0, 0, 0, 1, 5'd9,  5'd9,  5'd3,  1, 0);
      step("sup_jump",  1, 1, 0, 0, 1, 5'd4,  5'd4,  5'd4,  0, 0);
      step("jump",      1, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0);
      step("after_jmp", 1, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0);
      step("br_issue",  1, 0, 1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0);
      step("br_taken",  1, 1, 1, 1, 1, 5'd1,  5'd1,  5'd1,  0, 0);
      step("br_issue2", 1, 0, 1, 1, 0, 5'd0,  5'd1,  5'd2,  0, 0);
      step("br_ntaken", 1, 0, 1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0);
      step("br_again",  1, 0, 1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0);
      step("br_ntk2",   1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0);
      step("br_lu",     1, 0, 1, 0, 1, 5'd6,  5'd6,  5'd0,  0, 0);
      step("br_lu_go",  1, 0, 1, 0, 0, 5'd6,  5'd6,  5'd0,  0, 0);
      step("br_lu_res", 1, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0);
      step("br_rst_a",  1, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0);
      step("br_rst",    0, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0);
      step("post_rst",  1, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0);

      for (int i = 0; i < 20; i++) step("lu_sat", 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0);
`ifdef HAZARD_STATS_EN
      chk("stall_sat", {28'd0, StallCount}, 32'd15);
`endif

      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(0, 40) != 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0),
              1'($urandom),
              1'($urandom),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
